alu_issue_ctrl: RTL and testbench

- Issue-side controller for the 32-bit ALU: accepts decoded-instruction fields over a valid/ready handshake.
- Generates the 5-bit ALU operation code and the two operands, and drives them to the ALU from registers.
- Captures the ALU result and zero flag, then returns them over a valid/ready response channel.
- Sits between the decode stage and the ALU in the multicycle datapath.

---
 rtl/alu_issue_ctrl_pkg.sv | 43 ++++
 rtl/alu_op_decode.sv | 75 +++++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU operation codes,
// instruction opcode/funct field values, and the issue FSM state encoding.
// Imported by alu_op_decode and alu_issue_ctrl.
package alu_issue_ctrl_pkg;

  // ALU operation codes (5-bit)
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_XOR = 5'b00110;
  localparam logic [4:0] ALU_SUB = 5'b01100;
  localparam logic [4:0] ALU_SLT = 5'b01110;
  localparam logic [4:0] ALU_NOR = 5'b11100;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: maps opcode/funct/imm/rs/rt to the ALU
// operation code and operands, and flags instructions that are not recognised.
// Ports: opcode, funct, imm, rs_val, rt_val in; alu_op, op_a, op_b, illegal out.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              illegal
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

  assign op_a = rs_val;

  // Anything not recognised falls through to ADD rs+rt with illegal raised;
  // the top level decides whether the flag has any effect.
  always_comb begin
    alu_op  = ALU_ADD;
    op_b    = rt_val;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_op = ALU_ADD;
        op_b   = imm_sext;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT;
        op_b   = imm_sext;
      end
      OP_ANDI: begin
        alu_op = ALU_AND;
        op_b   = imm_zext;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        op_b   = imm_zext;
      end
      OP_XORI: begin
        alu_op = ALU_XOR;
        op_b   = imm_zext;
      end
      OP_BEQ, OP_BNE: begin
        alu_op = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU controller: accepts a decoded instruction (req_*), drives
// registered operands/op to the ALU for one cycle, captures result and zero
// flag, and returns them on the rsp_* valid/ready channel.
// Ports: clk, reset (sync, active-high); req_valid/req_ready + req_opcode,
// req_funct, req_rs_val, req_rt_val, req_imm; alu_opA/alu_opB/alu_op out,
// alu_result/alu_zero in; rsp_valid/rsp_ready + rsp_result, rsp_zero.
// Optional macro ALU_ISSUE_ILLEGAL_EN adds rsp_err and zeroes the result of
// unrecognised instructions.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_rs_val,
  input  logic [DATA_W-1:0] req_rt_val,
  input  logic [IMM_W-1:0]  req_imm,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic              rsp_err
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              capture;

  logic [4:0]        dec_op;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic              dec_illegal;
  logic              illegal_q;
`else
  // The decoder's illegal flag has no consumer in this build.
  logic              illegal_unused;
`endif

  alu_op_decode #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .opcode  (req_opcode),
    .funct   (req_funct),
    .imm     (req_imm),
    .rs_val  (req_rs_val),
    .rt_val  (req_rt_val),
    .alu_op  (dec_op),
    .op_a    (dec_a),
    .op_b    (dec_b),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .illegal (dec_illegal)
`else
    .illegal (illegal_unused)
`endif
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        // Response retiring this cycle frees the slot for a back-to-back accept.
        if (rsp_ready) begin
          req_ready = 1'b1;
          state_nxt = req_valid ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      req_ready = 1'b0;
    end
    accept = req_valid & req_ready;
  end

  // ALU input registers load only on accept, so they stay frozen through a
  // stalled response; result registers load only at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_op     <= ALU_AND;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q  <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_opA   <= dec_a;
        alu_opB   <= dec_b;
        alu_op    <= dec_op;
`ifdef ALU_ISSUE_ILLEGAL_EN
        illegal_q <= dec_illegal;
`endif
      end
      if (capture) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        // Illegal instructions still take the ALU slot, but its output is discarded.
        rsp_result <= illegal_q ? '0 : alu_result;
        rsp_zero   <= illegal_q ? 1'b0 : alu_zero;
        rsp_err    <= illegal_q;
`else
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_opcode;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_rs_val;
  logic [DATA_W-1:0] req_rt_val;
  logic [IMM_W-1:0]  req_imm;
  logic [DATA_W-1:0] alu_opA;
  logic [DATA_W-1:0] alu_opB;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic              rsp_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct  (req_funct),
    .req_rs_val (req_rs_val),
    .req_rt_val (req_rt_val),
    .req_imm    (req_imm),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  // External ALU model; SLT is an unsigned compare.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      5'b00000: alu_result = alu_opA & alu_opB;
      5'b00010: alu_result = alu_opA | alu_opB;
      5'b00100: alu_result = alu_opA + alu_opB;
      5'b00110: alu_result = alu_opA ^ alu_opB;
      5'b01100: alu_result = alu_opA - alu_opB;
      5'b01110: alu_result = {31'd0, (alu_opA < alu_opB)};
      5'b11100: alu_result = ~(alu_opA | alu_opB);
      default:  alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; caller guarantees req_ready.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm);
    req_opcode = opc;
    req_funct  = fn;
    req_rs_val = rs;
    req_rt_val = rt;
    req_imm    = imm;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_funct  = '0;
    req_rs_val = '0;
    req_rt_val = '0;
    req_imm    = '0;
    rsp_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_opA", alu_opA, 0);
    check("rst_alu_opB", alu_opB, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("rst_rsp_err", rsp_err, 0);
`endif
    reset = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1);

    // ADD 5+7
    send(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
    check("add_alu_op", alu_op, 32'b00100);
    check("add_opA", alu_opA, 5);
    check("add_opB", alu_opB, 7);
    check("add_issue_rsp_valid", rsp_valid, 0);
    check("add_issue_req_ready", req_ready, 0);
    tick();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_result", rsp_result, 12);
    check("add_zero", rsp_zero, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("add_err", rsp_err, 0);
`endif
    check("add_resp_req_ready", req_ready, 1);
    tick();
    check("add_done_rsp_valid", rsp_valid, 0);

    // BEQ equal operands
    send(6'h04, 6'h00, 32'h1234_5678, 32'h1234_5678, 16'h0);
    check("beq_alu_op", alu_op, 32'b01100);
    check("beq_opB", alu_opB, 32'h1234_5678);
    tick();
    check("beq_result", rsp_result, 0);
    check("beq_zero", rsp_zero, 1);
    tick();

    // ANDI zero-extends
    send(6'h0C, 6'h00, 32'hFFFF_1234, 32'h0, 16'hFFFF);
    check("andi_alu_op", alu_op, 32'b00000);
    check("andi_opB", alu_opB, 32'h0000_FFFF);
    tick();
    check("andi_result", rsp_result, 32'h0000_1234);
    tick();

    // ADDI sign-extends
    send(6'h08, 6'h00, 32'hFFFF_1234, 32'h0, 16'hFFFF);
    check("addi_alu_op", alu_op, 32'b00100);
    check("addi_opB", alu_opB, 32'hFFFF_FFFF);
    tick();
    check("addi_result", rsp_result, 32'hFFFF_1233);
    tick();

    // SW uses ADD with sign-extended offset
    send(6'h2B, 6'h00, 32'h0000_0100, 32'hDEAD_BEEF, 16'h8000);
    check("sw_alu_op", alu_op, 32'b00100);
    check("sw_opB", alu_opB, 32'hFFFF_8000);
    tick();
    check("sw_result", rsp_result, 32'hFFFF_8100);
    tick();

    // SLT is unsigned: 0xFFFFFFFF < 1 is false
    send(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0);
    check("slt_alu_op", alu_op, 32'b01110);
    tick();
    check("slt_result", rsp_result, 0);
    check("slt_zero", rsp_zero, 1);
    tick();

    // NOR of zeros
    send(6'h00, 6'h27, 32'h0, 32'h0, 16'h0);
    check("nor_alu_op", alu_op, 32'b11100);
    tick();
    check("nor_result", rsp_result, 32'hFFFF_FFFF);
    tick();

    // Backpressure: XOR response stalled five cycles while a new request waits
    rsp_ready = 1'b0;
    send(6'h00, 6'h26, 32'h0000_FF00, 32'h0F0F_0F0F, 16'h0);
    tick();
    req_opcode = 6'h00;
    req_funct  = 6'h20;
    req_rs_val = 32'd1;
    req_rt_val = 32'd2;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 32'h0F0F_F00F);
      check("bp_opA", alu_opA, 32'h0000_FF00);
      check("bp_opB", alu_opB, 32'h0F0F_0F0F);
      check("bp_alu_op", alu_op, 32'b00110);
      check("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("b2b_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("b2b_opA", alu_opA, 1);
    check("b2b_opB", alu_opB, 2);
    check("b2b_alu_op", alu_op, 32'b00100);
    check("b2b_issue_rsp_valid", rsp_valid, 0);
    tick();
    check("b2b_rsp_valid", rsp_valid, 1);
    check("b2b_result", rsp_result, 3);
    tick();

    // Reset during ISSUE aborts the request
    send(6'h00, 6'h20, 32'd9, 32'd9, 16'h0);
    check("abort_in_issue_opA", alu_opA, 9);
    reset = 1'b1;
    tick();
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_opA", alu_opA, 0);
    check("abort_opB", alu_opB, 0);
    check("abort_alu_op", alu_op, 0);
    check("abort_rsp_result", rsp_result, 0);
    check("abort_req_ready", req_ready, 0);
    reset = 1'b0;
    tick();
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_idle_ready", req_ready, 1);
    send(6'h00, 6'h25, 32'h0000_00F0, 32'h0000_000F, 16'h0);
    check("post_rst_alu_op", alu_op, 32'b00010);
    tick();
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_result", rsp_result, 32'h0000_00FF);
    tick();

    // Unlisted opcode 0x3F issues as ADD rs+rt
    send(6'h3F, 6'h00, 32'd3, 32'd4, 16'h1234);
    check("ill_alu_op", alu_op, 32'b00100);
    check("ill_opB", alu_opB, 4);
    tick();
    check("ill_rsp_valid", rsp_valid, 1);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("ill_err", rsp_err, 1);
    check("ill_result", rsp_result, 0);
    check("ill_zero", rsp_zero, 0);
`else
    check("ill_result", rsp_result, 7);
    check("ill_zero", rsp_zero, 0);
`endif
    tick();
    check("ill_done_rsp_valid", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
